one_to_four_dispatch_demux: RTL and testbench
=============================================

ONE_TO_FOUR_DISPATCH_DEMUX -- requirements
Module: one_to_four_dispatch_demux

Interface
REQ-001 SHALL provide parameter BITS, default 32, giving the data word width.
REQ-002 SHALL provide port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port IN_DATA  input  BITS  word to dispatch.
REQ-005 SHALL provide port IN_SELECT  input  2  destination channel index 0..3.
REQ-006 SHALL provide port IN_VALID  input  1  IN_DATA/IN_SELECT valid this cycle.
REQ-007 SHALL provide port IN_READY  output  1  dispatcher can accept a word for the selected channel this cycle.
REQ-008 SHALL provide port OUT_DATA  output  [3:0][BITS-1:0]  per-channel held word.
REQ-009 SHALL provide port OUT_VALID  output  4  per-channel word-present flag.
REQ-010 SHALL provide port OUT_READY  input  4  per-channel consumer accept.

Function
REQ-011 SHALL treat a transfer as accepted in a cycle where IN_VALID and IN_READY are both 1.
REQ-012 SHALL drive IN_READY combinationally as NOT OUT_VALID[IN_SELECT] OR OUT_READY[IN_SELECT]; it SHALL NOT depend on IN_VALID.
REQ-013 SHALL load an accepted word into channel IN_SELECT at the next rising edge and assert that channel's OUT_VALID, giving 1-cycle latency.
REQ-014 SHALL treat a channel word as consumed when OUT_VALID[i] and OUT_READY[i] are both 1, and SHALL clear OUT_VALID[i] at the next edge unless REQ-015 applies.
REQ-015 On consume and accept to the same channel in one cycle, SHALL replace OUT_DATA[i] with the new word and keep OUT_VALID[i]=1 with no bubble.
REQ-016 SHALL hold OUT_DATA[i] and OUT_VALID[i] stable while OUT_VALID[i]=1 and OUT_READY[i]=0.
REQ-017 SHALL retain the last OUT_DATA[i] after consumption; only OUT_VALID[i] qualifies it.
REQ-018 SHALL operate the four channels independently: a stalled channel SHALL NOT block accepts to other channels.
REQ-019 SHALL ignore IN_DATA and IN_SELECT when IN_VALID=0 and SHALL change no state.

Reset
REQ-020 While RST=1, SHALL force OUT_VALID=4'b0000 and every OUT_DATA[i] to 0 immediately, without waiting for CLK.
REQ-021 SHALL discard any word held or being accepted when RST asserts mid-operation; no transfer SHALL be reported after release.
REQ-022 SHALL accept a new word on the first rising edge after RST deasserts; IN_READY=1 then holds for all selects.

Configuration
REQ-023 With macro DISPATCH_COUNT_EN defined, SHALL add output COUNT  [3:0][7:0]  per-channel accepted-word counters, reset to 0, incremented on each accept to that channel, wrapping 255->0.
REQ-024 Without DISPATCH_COUNT_EN, SHALL have no COUNT port and no counter logic.

Structure
REQ-025 SHALL place channel-count constant (4), select width (2) and counter width (8) in shared package dispatch_pkg.
REQ-026 SHALL implement each channel as one instance of sub-module dispatch_channel_reg (one-entry register with valid/ready), instantiated four times.

Verification
REQ-027 After reset, IN_VALID=1, IN_SELECT=2, IN_DATA=32'hDEADBEEF, OUT_READY=4'b0000 -> next cycle OUT_VALID=4'b0100, OUT_DATA[2]=32'hDEADBEEF.
REQ-028 Channel 2 full, OUT_READY[2]=0, IN_SELECT=2 -> IN_READY=0, data held; IN_SELECT=1, IN_DATA=32'h11 -> accepted, OUT_VALID=4'b0110.
REQ-029 Channel 0 holding 32'hA, OUT_READY[0]=1, accept 32'hB to channel 0 same cycle -> next cycle OUT_VALID[0]=1, OUT_DATA[0]=32'hB.
REQ-030 RST pulsed between edges while OUT_VALID=4'b1111 -> OUT_VALID=0 and OUT_DATA all 0 before the next edge.
REQ-031 With DISPATCH_COUNT_EN, 257 accepts to channel 3 with OUT_READY[3]=1 -> COUNT[3]=1, other counts 0.
REQ-032 IN_VALID=0 with IN_SELECT toggling for 10 cycles -> OUT_VALID unchanged, no counter increments.

Source files
------------

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared sizing constants for the one-to-four dispatcher
package dispatch_pkg;
  localparam int CHANNELS = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;
endpackage

// File: rtl/dispatch_channel_reg.sv
// dispatch_channel_reg: one-entry register with valid/ready handshake
//   clk, rst   : clock, async active-high reset
//   load       : word accepted for this channel this cycle
//   din        : word to store on load
//   ready      : consumer accepts the held word
//   valid/dout : word-present flag and held word (dout kept after consume)
module dispatch_channel_reg #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [BITS-1:0] din,
  input  logic            ready,
  output logic            valid,
  output logic [BITS-1:0] dout
);
  // load wins over consume so a same-cycle replace leaves valid high with no bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/one_to_four_dispatch_demux.sv
// one_to_four_dispatch_demux: routes a valid/ready word stream to one of four held channels
//   CLK, RST  : clock, async active-high reset
//   IN_DATA, IN_SELECT, IN_VALID, IN_READY : upstream handshake
//   OUT_DATA, OUT_VALID, OUT_READY         : per-channel downstream handshake
//   COUNT     : per-channel accepted-word counters, present only with DISPATCH_COUNT_EN
module one_to_four_dispatch_demux
  import dispatch_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [BITS-1:0]               IN_DATA,
  input  logic [SEL_W-1:0]              IN_SELECT,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic [CHANNELS-1:0][BITS-1:0] OUT_DATA,
  output logic [CHANNELS-1:0]           OUT_VALID,
`ifdef DISPATCH_COUNT_EN
  output logic [CHANNELS-1:0][CNT_W-1:0] COUNT,
`endif
  input  logic [CHANNELS-1:0]           OUT_READY
);
  logic [CHANNELS-1:0] load;
  assign IN_READY = !OUT_VALID[IN_SELECT] || OUT_READY[IN_SELECT];
  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      assign load[i] = IN_VALID && IN_READY && (IN_SELECT == SEL_W'(i));
      dispatch_channel_reg #(.BITS(BITS)) u_reg (
        .clk  (CLK),
        .rst  (RST),
        .load (load[i]),
        .din  (IN_DATA),
        .ready(OUT_READY[i]),
        .valid(OUT_VALID[i]),
        .dout (OUT_DATA[i])
      );
`ifdef DISPATCH_COUNT_EN
      always_ff @(posedge CLK or posedge RST)
        if (RST) COUNT[i] <= '0;
        else if (load[i]) COUNT[i] <= COUNT[i] + 1'b1;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_one_to_four_dispatch_demux.sv
// tb_one_to_four_dispatch_demux: table-driven self-checking bench for the dispatcher
module tb_one_to_four_dispatch_demux;
  logic             clk = 0;
  logic             rst;
  logic [31:0]      in_data;
  logic [1:0]       in_select;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][31:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef DISPATCH_COUNT_EN
  logic [3:0][7:0]  count;
`endif
  int checks = 0;
  int failures = 0;

  one_to_four_dispatch_demux #(.BITS(32)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_SELECT(in_select),
    .IN_VALID(in_valid), .IN_READY(in_ready), .OUT_DATA(out_data),
    .OUT_VALID(out_valid),
`ifdef DISPATCH_COUNT_EN
    .COUNT(count),
`endif
    .OUT_READY(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        exp_irdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [31:0] d, input logic [3:0] ordy);
    in_valid = iv;
    in_select = sel;
    in_data = d;
    out_ready = ordy;
  endtask

  initial begin
    tbl[0]  = '{1, 2, 32'hDEADBEEF, 4'b0000, 1, 4'b0100, 32'hDEADBEEF};
    tbl[1]  = '{1, 2, 32'h12345678, 4'b0000, 0, 4'b0100, 32'hDEADBEEF};
    tbl[2]  = '{1, 1, 32'h11,       4'b0000, 1, 4'b0110, 32'h11};
    tbl[3]  = '{0, 0, 32'hFFFF,     4'b0000, 1, 4'b0110, 32'h0};
    tbl[4]  = '{1, 0, 32'hA,        4'b0000, 1, 4'b0111, 32'hA};
    tbl[5]  = '{1, 0, 32'hB,        4'b0001, 1, 4'b0111, 32'hB};
    tbl[6]  = '{0, 1, 32'h999,      4'b0010, 1, 4'b0101, 32'h11};
    tbl[7]  = '{1, 3, 32'hC0DE,     4'b0100, 1, 4'b1001, 32'hC0DE};
    tbl[8]  = '{1, 3, 32'h55,       4'b0000, 0, 4'b1001, 32'hC0DE};
    tbl[9]  = '{0, 2, 32'h66,       4'b0000, 1, 4'b1001, 32'hDEADBEEF};
    tbl[10] = '{1, 1, 32'h77,       4'b1001, 1, 4'b0010, 32'h77};
    tbl[11] = '{1, 0, 32'h88,       4'b0000, 1, 4'b0011, 32'h88};

    drive(0, 0, 0, 0);
    rst = 1;
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'h0);
    chk("reset_out_data", 128'(out_data), 128'h0);
    @(negedge clk);
    rst = 0;
    #1;
    for (int s = 0; s < 4; s++) begin
      in_select = 2'(s);
      #1;
      chk($sformatf("reset_in_ready_sel%0d", s), 128'(in_ready), 128'h1);
    end

    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      drive(tbl[n].iv, tbl[n].sel, tbl[n].data, tbl[n].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", n), 128'(in_ready), 128'(tbl[n].exp_irdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", n), 128'(out_valid), 128'(tbl[n].exp_ov));
      chk($sformatf("vec%0d_out_data", n), 128'(out_data[tbl[n].sel]), 128'(tbl[n].exp_d));
    end

    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      drive(0, 2'(n), $urandom, 4'b0000);
    end
    @(posedge clk);
    #1;
    chk("idle_out_valid", 128'(out_valid), 128'h3);
    chk("idle_data0", 128'(out_data[0]), 128'h88);
    chk("idle_data1", 128'(out_data[1]), 128'h77);

    for (int s = 2; s < 4; s++) begin
      @(negedge clk);
      drive(1, 2'(s), 32'h100 + s, 4'b0000);
    end
    @(posedge clk);
    #1;
    chk("full_out_valid", 128'(out_valid), 128'hF);
    #2;
    rst = 1;
    #1;
    chk("async_rst_out_valid", 128'(out_valid), 128'h0);
    chk("async_rst_out_data", 128'(out_data), 128'h0);
    @(negedge clk);
    drive(1, 3, 32'h99, 4'b0000);
    rst = 0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'h1);
    chk("post_rst_no_transfer", 128'(out_valid), 128'h0);
    @(posedge clk);
    #1;
    chk("post_rst_accept_valid", 128'(out_valid), 128'h8);
    chk("post_rst_accept_data", 128'(out_data[3]), 128'h99);

`ifdef DISPATCH_COUNT_EN
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1;
    #1;
    chk("count_reset", 128'(count), 128'h0);
    rst = 0;
    for (int n = 0; n < 257; n++) begin
      @(negedge clk);
      drive(1, 3, 32'(n), 4'b1000);
    end
    @(posedge clk);
    #1;
    chk("count_wrap", 128'(count), 128'h01000000);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      drive(0, 2'(n), 32'hF00D, 4'b0000);
    end
    @(posedge clk);
    #1;
    chk("count_idle", 128'(count), 128'h01000000);
    chk("count_idle_valid", 128'(out_valid), 128'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
